// File: rtl/plane_move.sv
// Player sprite mover: press-to-step then auto-repeat every MOVE_DIV cycles,
// with saturation at the screen bounds and a one-cycle edge-hit pulse.
module plane_move #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PLANE_W  = 32,
    parameter int PLANE_H  = 32,
    parameter int STEP     = 4,
    parameter int MOVE_DIV = 250000,
    parameter int X_INIT   = 304,
    parameter int Y_INIT   = 432
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_en_i,
    input  logic [1:0] direct_i,
    input  logic       freeze_i,
    output logic [9:0] plane_x_o,
    output logic [8:0] plane_y_o,
    output logic       moving_o,
    output logic       edge_hit_o
);

    localparam int CW = $clog2(MOVE_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(MOVE_DIV - 1);
    localparam logic [10:0]   X_MAX  = 11'(SCREEN_W - PLANE_W);
    localparam logic [9:0]    Y_MAX  = 10'(SCREEN_H - PLANE_H);

    typedef enum logic {
        IDLE,
        MOVE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [9:0]      x_nxt;
    logic [8:0]      y_nxt;
    logic            hit_nxt;
    logic            go;
    logic            step;
    logic [10:0]     x_dec;
    logic [10:0]     x_inc;
    logic [9:0]      y_dec;
    logic [9:0]      y_inc;

    assign go = move_en_i & ~freeze_i;

    // One extra bit: borrow flags underflow, the carry room shows overflow.
    assign x_dec = {1'b0, plane_x_o} - 11'(STEP);
    assign x_inc = {1'b0, plane_x_o} + 11'(STEP);
    assign y_dec = {1'b0, plane_y_o} - 10'(STEP);
    assign y_inc = {1'b0, plane_y_o} + 10'(STEP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = MOVE;
                    cnt_nxt   = RELOAD;
                    step      = 1'b1;
                end
            end
            MOVE: begin
                if (!go) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    cnt_nxt = RELOAD;
                    step    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        x_nxt   = plane_x_o;
        y_nxt   = plane_y_o;
        hit_nxt = 1'b0;
        if (step) begin
            unique case (direct_i)
                2'b00: begin
                    if (y_dec[9]) begin
                        y_nxt   = '0;
                        hit_nxt = 1'b1;
                    end else begin
                        y_nxt = y_dec[8:0];
                    end
                end
                2'b01: begin
                    if (y_inc > Y_MAX) begin
                        y_nxt   = Y_MAX[8:0];
                        hit_nxt = 1'b1;
                    end else begin
                        y_nxt = y_inc[8:0];
                    end
                end
                2'b10: begin
                    if (x_dec[10]) begin
                        x_nxt   = '0;
                        hit_nxt = 1'b1;
                    end else begin
                        x_nxt = x_dec[9:0];
                    end
                end
                2'b11: begin
                    if (x_inc > X_MAX) begin
                        x_nxt   = X_MAX[9:0];
                        hit_nxt = 1'b1;
                    end else begin
                        x_nxt = x_inc[9:0];
                    end
                end
                default: begin
                    x_nxt = plane_x_o;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            plane_x_o  <= 10'(X_INIT);
            plane_y_o  <= 9'(Y_INIT);
            moving_o   <= 1'b0;
            edge_hit_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            plane_x_o  <= x_nxt;
            plane_y_o  <= y_nxt;
            moving_o   <= (state_nxt == MOVE);
            edge_hit_o <= hit_nxt;
        end
    end

endmodule

// File: tb/tb_plane_move.sv
// Bench for plane_move: directed scenarios plus random button activity,
// all outputs compared every cycle against a behavioural model.
module tb_plane_move;

    localparam int DIV  = 4;
    localparam int STP  = 4;
    localparam int XMAX = 640 - 32;
    localparam int YMAX = 480 - 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       move_en_i = 1'b0;
    logic [1:0] direct_i = 2'b00;
    logic       freeze_i = 1'b0;
    logic [9:0] plane_x_o;
    logic [8:0] plane_y_o;
    logic       moving_o;
    logic       edge_hit_o;

    int total = 0;
    int bad = 0;

    // Reference state: position, whether a press is active,
    // and cycles elapsed since the last step.
    int m_x = 304;
    int m_y = 432;
    bit m_mov = 0;
    bit m_hit = 0;
    int m_age = 0;

    plane_move #(
        .STEP(STP),
        .MOVE_DIV(DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .move_en_i(move_en_i),
        .direct_i(direct_i),
        .freeze_i(freeze_i),
        .plane_x_o(plane_x_o),
        .plane_y_o(plane_y_o),
        .moving_o(moving_o),
        .edge_hit_o(edge_hit_o)
    );

    always #5 clk = ~clk;

    function automatic int clampv(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_step(input logic [1:0] d);
        int nx;
        int ny;
        nx = m_x;
        ny = m_y;
        case (d)
            2'b00: ny = m_y - STP;
            2'b01: ny = m_y + STP;
            2'b10: nx = m_x - STP;
            default: nx = m_x + STP;
        endcase
        m_hit = (nx < 0) || (nx > XMAX) || (ny < 0) || (ny > YMAX);
        m_x = clampv(nx, XMAX);
        m_y = clampv(ny, YMAX);
    endtask

    task automatic model_edge(input bit r, input bit en,
                              input logic [1:0] d, input bit fr);
        bit go;
        go = en && !fr;
        m_hit = 0;
        if (r) begin
            m_x = 304;
            m_y = 432;
            m_mov = 0;
            m_age = 0;
        end else if (!m_mov) begin
            if (go) begin
                m_mov = 1;
                m_age = 0;
                model_step(d);
            end
        end else if (!go) begin
            m_mov = 0;
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == DIV) begin
                m_age = 0;
                model_step(d);
            end
        end
    endtask

    task automatic check_all(input string tag);
        total++;
        assert (plane_x_o === 10'(m_x)) else begin
            bad++;
            $error("FAIL %s x: got %0d want %0d", tag, plane_x_o, m_x);
        end
        total++;
        assert (plane_y_o === 9'(m_y)) else begin
            bad++;
            $error("FAIL %s y: got %0d want %0d", tag, plane_y_o, m_y);
        end
        total++;
        assert (moving_o === m_mov) else begin
            bad++;
            $error("FAIL %s moving: got %b want %b", tag, moving_o, m_mov);
        end
        total++;
        assert (edge_hit_o === m_hit) else begin
            bad++;
            $error("FAIL %s hit: got %b want %b", tag, edge_hit_o, m_hit);
        end
    endtask

    task automatic cyc(input string tag, input bit r, input bit en,
                       input logic [1:0] d, input bit fr);
        rst = r;
        move_en_i = en;
        direct_i = d;
        freeze_i = fr;
        @(posedge clk);
        model_edge(r, en, d, fr);
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n, input bit en,
                       input logic [1:0] d, input bit fr);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, en, d, fr);
    endtask

    initial begin
        cyc("reset", 1'b1, 1'b0, 2'b00, 1'b0);
        cyc("reset", 1'b1, 1'b1, 2'b11, 1'b0);

        // First step one edge after the press, then every DIV cycles.
        cyc("right1", 1'b0, 1'b1, 2'b11, 1'b0);
        total++;
        assert (plane_x_o === 10'd308 && moving_o === 1'b1) else begin
            bad++;
            $error("FAIL right_first: got x=%0d mv=%b want 308/1",
                   plane_x_o, moving_o);
        end
        run("right", 4, 1'b1, 2'b11, 1'b0);
        total++;
        assert (plane_x_o === 10'd312) else begin
            bad++;
            $error("FAIL right_second: got %0d want 312", plane_x_o);
        end
        run("right", 4, 1'b1, 2'b11, 1'b0);
        total++;
        assert (plane_x_o === 10'd316) else begin
            bad++;
            $error("FAIL right_third: got %0d want 316", plane_x_o);
        end

        // Direction change mid-period keeps the schedule.
        run("turn", 2, 1'b1, 2'b11, 1'b0);
        run("turn", 4, 1'b1, 2'b00, 1'b0);
        run("rel", 2, 1'b0, 2'b00, 1'b0);

        // Left wall, then right wall.
        run("left", 360, 1'b1, 2'b10, 1'b0);
        run("rel", 1, 1'b0, 2'b10, 1'b0);
        run("rwall", 660, 1'b1, 2'b11, 1'b0);

        // Bottom, then top.
        run("down", 40, 1'b1, 2'b01, 1'b0);
        run("up", 500, 1'b1, 2'b00, 1'b0);

        // Freeze holds everything; release re-steps at once.
        run("frz", 10, 1'b1, 2'b01, 1'b1);
        run("unfrz", 3, 1'b1, 2'b01, 1'b0);

        // Reset on a stepping edge wins.
        run("pre", 3, 1'b1, 2'b11, 1'b0);
        cyc("rstmv", 1'b1, 1'b1, 2'b11, 1'b0);
        total++;
        assert (plane_x_o === 10'd304 && plane_y_o === 9'd432 &&
                moving_o === 1'b0 && edge_hit_o === 1'b0) else begin
            bad++;
            $error("FAIL rst_mid: got %0d,%0d,%b,%b want 304,432,0,0",
                   plane_x_o, plane_y_o, moving_o, edge_hit_o);
        end

        // Random presses with held durations.
        for (int k = 0; k < 400; k++) begin
            bit en;
            bit fr;
            logic [1:0] d;
            int len;
            en = ($urandom_range(0, 3) != 0);
            fr = ($urandom_range(0, 9) == 0);
            d = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 15) == 0) d = 2'($urandom_range(0, 3));
                cyc("rand", ($urandom_range(0, 199) == 0), en, d, fr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plane_move.md
PLANE_MOVE -- requirements
Module: plane_move

Parameters
REQ-001 SHALL provide SCREEN_W, default 640, screen width in pixels.
REQ-002 SHALL provide SCREEN_H, default 480, screen height in pixels.
REQ-003 SHALL provide PLANE_W / PLANE_H, default 32 / 32, player sprite size in pixels.
REQ-004 SHALL provide STEP, default 4, pixels moved per step.
REQ-005 SHALL provide MOVE_DIV, default 250000, clk cycles between repeat steps; legal range >= 2.
REQ-006 SHALL provide X_INIT / Y_INIT, default 304 / 432, spawn position (top-left corner of sprite).

Interface
REQ-007 SHALL have clk, input, 1, single system clock; all logic on posedge.
REQ-008 SHALL have rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have move_en_i, input, 1, level: exactly one direction button held (from button encoder).
REQ-010 SHALL have direct_i, input, 2, direction: UP=2'b00, DOWN=2'b01, LEFT=2'b10, RIGHT=2'b11.
REQ-011 SHALL have freeze_i, input, 1, level: game paused/over; movement inhibited.
REQ-012 SHALL have plane_x_o, output, 10, registered sprite X.
REQ-013 SHALL have plane_y_o, output, 9, registered sprite Y.
REQ-014 SHALL have moving_o, output, 1, registered, high while FSM in MOVE.
REQ-015 SHALL have edge_hit_o, output, 1, registered one-cycle pulse when a step is clamped at a boundary.

Function
REQ-016 SHALL implement FSM with states IDLE and MOVE, plus a repeat counter of ceil(log2(MOVE_DIV)) bits.
REQ-017 IDLE -> MOVE when move_en_i=1 and freeze_i=0; in that same edge perform one step (first step latency 1 cycle after input seen) and load counter with MOVE_DIV-1.
REQ-018 In MOVE with move_en_i=1, freeze_i=0: counter decrements each cycle; when counter=0, perform one step and reload MOVE_DIV-1 (repeat period exactly MOVE_DIV cycles).
REQ-019 MOVE -> IDLE when move_en_i=0 or freeze_i=1; counter cleared to 0; no step on that edge.
REQ-020 Step direction SHALL be direct_i sampled on the stepping edge; direction change inside MOVE does not restart the counter nor trigger an extra step.
REQ-021 UP: y <= y-STEP; DOWN: y <= y+STEP; LEFT: x <= x-STEP; RIGHT: x <= x+STEP.
REQ-022 Arithmetic SHALL be done one bit wider than the coordinate to detect underflow/overflow; results saturate to X range [0, SCREEN_W-PLANE_W] and Y range [0, SCREEN_H-PLANE_H].
REQ-023 edge_hit_o SHALL pulse high for exactly the cycle after a step whose unclamped result lies outside range (includes stepping while already at the bound); low otherwise.
REQ-024 freeze_i=1 SHALL hold plane_x_o/plane_y_o; on release with move_en_i still 1, behave as a fresh press (immediate step, per REQ-017).
REQ-025 moving_o SHALL equal (state==MOVE) registered; no combinational path from inputs to any output.

Reset
REQ-026 On rst=1 at posedge: plane_x_o=X_INIT, plane_y_o=Y_INIT, state=IDLE, counter=0, moving_o=0, edge_hit_o=0.
REQ-027 rst SHALL dominate all other inputs, including mid-MOVE and same-cycle step; first step after release requires REQ-017 conditions.

Verification (bench uses MOVE_DIV=4, STEP=4, defaults otherwise)
REQ-028 Reset then move_en_i=1, direct_i=RIGHT held 9 cycles -> x: 304->308 at cycle 1, 312 at cycle 5, 316 at cycle 9; moving_o=1 from cycle 1.
REQ-029 From x=4, LEFT held -> x=0 after first step, edge_hit_o=0; next step x stays 0, edge_hit_o=1 for one cycle.
REQ-030 From y=446, DOWN held -> y saturates at 448 with edge_hit_o pulse; subsequent steps keep 448 and pulse each step.
REQ-031 MOVE with RIGHT, switch direct_i to UP at counter=2 -> next step occurs on schedule and decrements y by 4; x unchanged.
REQ-032 freeze_i=1 for 10 cycles while move_en_i=1 -> position constant, moving_o=0; freeze_i=0 -> step on next edge.
REQ-033 rst=1 asserted during MOVE on a stepping cycle -> next cycle x=304, y=432, moving_o=0, edge_hit_o=0.
